// File: rtl/ifu_fetch_queue_if.sv
// Fetch-unit bus: decode-side valid/ready handshake, redirect request and
// program-load write port. The fetch unit takes the master side.
interface ifu_fetch_queue_if #(
    parameter int AW = 8
);
    logic          branch_taken;
    logic [31:0]   branch_target;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst_pc;
    logic [31:0]   inst_data;
    logic          inst_fault;
    logic [1:0]    inst_fault_cause;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;

    modport master (
        input  branch_taken, branch_target, inst_ready,
        input  imem_we, imem_waddr, imem_wdata,
        output inst_valid, inst_pc, inst_data, inst_fault, inst_fault_cause
    );

    modport slave (
        output branch_taken, branch_target, inst_ready,
        output imem_we, imem_waddr, imem_wdata,
        input  inst_valid, inst_pc, inst_data, inst_fault, inst_fault_cause
    );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch unit: synchronous instruction memory feeding a small
// circular fetch queue toward decode, with redirect flush and fault tagging.
module ifu_fetch_queue #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          IMEM_DEPTH   = 256,
    parameter int          FQ_DEPTH     = 4,
    parameter int          AW           = $clog2(IMEM_DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    ifu_fetch_queue_if.master   bus
);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_LIMIT = (CW+1)'(FQ_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
        logic [1:0]  cause;
    } fq_entry_t;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic          inflight_fault_q, inflight_fault_d;
    logic [1:0]    inflight_cause_q, inflight_cause_d;
    logic          stop_q, stop_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   imem [IMEM_DEPTH];
    logic [31:0]   rdata_q;
    fq_entry_t     fq_mem [FQ_DEPTH];

    logic          fq_valid;
    logic          pop;
    logic          push;
    logic          issue;
    logic          issue_read;
    logic [1:0]    issue_cause;
    fq_entry_t     head_ent;
    fq_entry_t     push_ent;

    assign fq_valid = (count_q != '0);
    assign head_ent = fq_mem[head_q];

    // Outputs are forced to zero whenever the queue is empty so stale
    // storage never leaks out after reset or a flush.
    assign bus.inst_valid       = fq_valid;
    assign bus.inst_pc          = fq_valid ? head_ent.pc    : '0;
    assign bus.inst_data        = fq_valid ? head_ent.data  : '0;
    assign bus.inst_fault       = fq_valid ? head_ent.fault : 1'b0;
    assign bus.inst_fault_cause = fq_valid ? head_ent.cause : 2'b00;

    always_comb begin
        issue_cause = 2'b00;
        if (fetch_pc_q[1:0] != 2'b00) begin
            issue_cause = 2'b01;
        end else if (fetch_pc_q[31:AW+2] != '0) begin
            issue_cause = 2'b10;
        end

        pop        = fq_valid && bus.inst_ready;
        push       = inflight_q && !bus.branch_taken;
        issue      = (({1'b0, count_q} + {{CW{1'b0}}, inflight_q}) < DEPTH_LIMIT)
                     && !stop_q && !bus.branch_taken;
        issue_read = issue && (issue_cause == 2'b00);

        push_ent.pc    = inflight_pc_q;
        push_ent.data  = inflight_fault_q ? 32'h0 : rdata_q;
        push_ent.fault = inflight_fault_q;
        push_ent.cause = inflight_cause_q;

        fetch_pc_d       = fetch_pc_q;
        inflight_d       = 1'b0;
        inflight_pc_d    = inflight_pc_q;
        inflight_fault_d = inflight_fault_q;
        inflight_cause_d = inflight_cause_q;
        stop_d           = stop_q;
        head_d           = head_q;
        tail_d           = tail_q;
        count_d          = count_q;

        if (bus.branch_taken) begin
            // A same-cycle head transfer is already consumed by decode;
            // everything else, including the in-flight read, is dropped.
            fetch_pc_d = bus.branch_target;
            stop_d     = 1'b0;
            head_d     = tail_q;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d       = fetch_pc_q + 32'd4;
                inflight_d       = 1'b1;
                inflight_pc_d    = fetch_pc_q;
                inflight_fault_d = (issue_cause != 2'b00);
                inflight_cause_d = issue_cause;
                stop_d           = (issue_cause != 2'b00);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q       <= RESET_VECTOR;
            inflight_q       <= 1'b0;
            inflight_pc_q    <= '0;
            inflight_fault_q <= 1'b0;
            inflight_cause_q <= 2'b00;
            stop_q           <= 1'b0;
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
        end else begin
            fetch_pc_q       <= fetch_pc_d;
            inflight_q       <= inflight_d;
            inflight_pc_q    <= inflight_pc_d;
            inflight_fault_q <= inflight_fault_d;
            inflight_cause_q <= inflight_cause_d;
            stop_q           <= stop_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
        end
    end

    // Read-before-write: a same-address load in the fetch cycle returns old data.
    always_ff @(posedge clk) begin
        if (bus.imem_we) begin
            imem[bus.imem_waddr] <= bus.imem_wdata;
        end
        if (issue_read) begin
            rdata_q <= imem[fetch_pc_q[AW+1:2]];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fq_mem[tail_q] <= push_ent;
        end
    end
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: directed vector table, hand-written corner
// sequences and a randomized run checked against a queue-based model.
module tb_ifu_fetch_queue;
    localparam logic [31:0] RV0 = 32'h0000_0000;
    localparam logic [31:0] RV1 = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic        we;
    logic [7:0]  waddr;
    logic [31:0] wdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ifu_fetch_queue_if #(.AW(8)) bus ();
    ifu_fetch_queue_if #(.AW(8)) bus_rv ();

    assign bus.branch_taken     = br;
    assign bus.branch_target    = tgt;
    assign bus.inst_ready       = rdy;
    assign bus.imem_we          = we;
    assign bus.imem_waddr       = waddr;
    assign bus.imem_wdata       = wdata;
    assign bus_rv.branch_taken  = br;
    assign bus_rv.branch_target = tgt;
    assign bus_rv.inst_ready    = rdy;
    assign bus_rv.imem_we       = we;
    assign bus_rv.imem_waddr    = waddr;
    assign bus_rv.imem_wdata    = wdata;

    ifu_fetch_queue #(.RESET_VECTOR(RV0), .IMEM_DEPTH(256), .FQ_DEPTH(4)) u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    ifu_fetch_queue #(.RESET_VECTOR(RV1), .IMEM_DEPTH(256), .FQ_DEPTH(4)) u_dut_rv (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_rv)
    );

    // Reference model: a list of queued entries and a list of reads in flight.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
        logic [1:0]  cause;
    } ent_t;

    ent_t        m_q[$];
    ent_t        m_pend[$];
    logic [31:0] m_pc = RV0;
    bit          m_stop = 1'b0;
    logic [31:0] m_mem [256];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        ent_t e;
        int   occ;
        int   infl;
        bit   issue;
        occ = m_q.size();
        infl = m_pend.size();
        if (rst) begin
            m_q.delete();
            m_pend.delete();
            m_pc   = RV0;
            m_stop = 1'b0;
        end else if (br) begin
            m_q.delete();
            m_pend.delete();
            m_pc   = tgt;
            m_stop = 1'b0;
        end else begin
            issue = (occ + infl < 4) && !m_stop;
            if (occ > 0 && rdy) void'(m_q.pop_front());
            if (infl > 0) m_q.push_back(m_pend.pop_front());
            if (issue) begin
                e = '{pc: m_pc, data: 32'h0, fault: 1'b0, cause: 2'b00};
                if (m_pc % 4 != 0) begin
                    e.fault = 1'b1;
                    e.cause = 2'b01;
                end else if ((m_pc / 4) >= 256) begin
                    e.fault = 1'b1;
                    e.cause = 2'b10;
                end else begin
                    e.data = m_mem[m_pc[9:2]];
                end
                if (e.fault) m_stop = 1'b1;
                m_pend.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        if (we) m_mem[waddr] = wdata;
    endtask

    task automatic model_check();
        logic [71:0] exp;
        logic [71:0] act;
        exp = '0;
        if (m_q.size() > 0) exp = {4'b0, 1'b1, m_q[0]};
        act = {4'b0, bus.inst_valid, bus.inst_pc, bus.inst_data,
               bus.inst_fault, bus.inst_fault_cause};
        chk("model_head", act, exp);
    endtask

    task automatic tick();
        if (bus.inst_valid && rdy && !rst)
            $display("xfer pc=%h data=%h fault=%0d cause=%0d",
                     bus.inst_pc, bus.inst_data, bus.inst_fault, bus.inst_fault_cause);
        @(posedge clk);
        model_step();
        #1;
        model_check();
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic rd, input logic v, input logic [31:0] pc);
        vec_t x;
        x.rst       = r;
        x.rdy       = rd;
        x.exp_valid = v;
        x.exp_pc    = pc;
        x.exp_data  = v ? 32'h0000_0013 : 32'h0;
        tbl.push_back(x);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        logic [31:0] r;

        rst = 1'b1; rdy = 1'b0; br = 1'b0; tgt = '0;
        we = 1'b0; waddr = '0; wdata = '0;

        for (int i = 0; i < 256; i++) begin
            we    = 1'b1;
            waddr = 8'(i);
            wdata = (i < 8) ? 32'h0000_0013 : {16'hA5A5, 16'(i)};
            tick();
        end
        we = 1'b0;

        // Startup with decode ready, reset mid-stream, then a 10-cycle stall.
        add(1, 1, 0, 0); add(0, 1, 0, 0);
        add(0, 1, 1, 0); add(0, 1, 1, 4); add(0, 1, 1, 8); add(0, 1, 1, 12);
        add(1, 1, 0, 0); add(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 0, 1, 0);
        add(0, 1, 1, 4); add(0, 1, 1, 8); add(0, 1, 1, 12); add(0, 1, 1, 16); add(0, 1, 1, 20);

        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            rdy = tbl[i].rdy;
            tick();
            chk($sformatf("vec%0d", i),
                {bus.inst_valid, bus.inst_pc, bus.inst_data, bus.inst_fault, bus.inst_fault_cause},
                {tbl[i].exp_valid, tbl[i].exp_pc, tbl[i].exp_data, 1'b0, 2'b00});
        end

        // Redirect to 0x40 while three entries wait and decode stalls.
        rdy = 1'b0;
        for (int k = 0; k < 10 && m_q.size() != 3; k++) tick();
        chk("pre_redirect_valid", bus.inst_valid, 1);
        br = 1'b1; tgt = 32'h40;
        tick();
        br = 1'b0;
        chk("redirect_drop", bus.inst_valid, 0);
        tick();
        chk("redirect_gap", bus.inst_valid, 0);
        tick();
        chk("redirect_target", {bus.inst_valid, bus.inst_pc, bus.inst_data},
            {1'b1, 32'h40, 32'hA5A5_0010});

        // Misaligned redirect: one fault entry, then silence.
        br = 1'b1; tgt = 32'h42;
        tick();
        br = 1'b0;
        tick(); tick();
        chk("misalign_entry",
            {bus.inst_valid, bus.inst_pc, bus.inst_data, bus.inst_fault, bus.inst_fault_cause},
            {1'b1, 32'h42, 32'h0, 1'b1, 2'b01});
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("misalign_stable", {bus.inst_valid, bus.inst_pc}, {1'b1, 32'h42});
        end
        rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("fault_stop", bus.inst_valid, 0);
        end
        br = 1'b1; tgt = 32'h0;
        tick();
        br = 1'b0;
        tick(); tick();
        chk("resume_after_fault",
            {bus.inst_valid, bus.inst_pc, bus.inst_data, bus.inst_fault},
            {1'b1, 32'h0, 32'h13, 1'b0});

        // Run off the end of instruction memory.
        br = 1'b1; tgt = 32'h3F0;
        tick();
        br = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (bus.inst_valid && bus.inst_pc == 32'h400) found = 1'b1;
        end
        chk("range_found", found, 1);
        chk("range_entry", {bus.inst_data, bus.inst_fault, bus.inst_fault_cause},
            {32'h0, 1'b1, 2'b10});
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("range_stop", bus.inst_valid, 0);
        end

        // Reset with a stalled queue and a read in flight.
        rdy = 1'b0;
        br = 1'b1; tgt = 32'h0;
        tick();
        br = 1'b0;
        for (int k = 0; k < 10 && !(m_q.size() == 3 && m_pend.size() == 1); k++) tick();
        chk("pre_reset_valid", bus.inst_valid, 1);
        rst = 1'b1;
        tick();
        chk("reset_flush", {bus.inst_valid, bus.inst_pc, bus_rv.inst_valid, bus_rv.inst_pc},
            {1'b0, 32'h0, 1'b0, 32'h0});
        rst = 1'b0; rdy = 1'b1;
        tick();
        chk("reset_latency", {bus.inst_valid, bus_rv.inst_valid}, 2'b00);
        tick();
        chk("reset_vector_0", {bus.inst_valid, bus.inst_pc}, {1'b1, 32'h0});
        chk("reset_vector_80", {bus_rv.inst_valid, bus_rv.inst_pc, bus_rv.inst_data},
            {1'b1, 32'h80, 32'hA5A5_0020});

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) < 2);
            rdy = ($urandom_range(0, 9) < 7);
            br  = ($urandom_range(0, 99) < 6);
            r   = $urandom;
            case ($urandom_range(0, 7))
                0, 1, 2, 3, 4: tgt = {22'h0, r[7:0], 2'b00};
                5:             tgt = 32'h3F0 + {28'h0, r[1:0], 2'b00};
                6:             tgt = {22'h0, r[7:0], 2'b00} | {30'h0, 2'($urandom_range(1, 3))};
                default:       tgt = {r[31:2], 2'b00};
            endcase
            we    = ($urandom_range(0, 4) == 0);
            waddr = 8'($urandom);
            wdata = $urandom;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
